// File: rtl/encoder_weight_sink.sv
// encoder_weight_sink: valid/ready weight-stream sink into a buffer RAM with a ROM-style read port.
// Optional running lane checksum is built only when WEIGHT_SINK_CHECKSUM_EN is defined.
`default_nettype none

module encoder_weight_sink #(
  parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
  parameter int WEIGHT_TENSOR_SIZE_DIM_1 = 1,
  parameter int WEIGHT_PRECISION_0       = 16,
  parameter int WEIGHT_PRECISION_1       = 3,
  parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
  parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
  parameter int IN_DEPTH   = (WEIGHT_TENSOR_SIZE_DIM_0 * WEIGHT_TENSOR_SIZE_DIM_1) /
                             (WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1),
  parameter int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WEIGHT_PRECISION_0-1:0] data_in [WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1],
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic                          load_start,
  output logic                          load_done,
  output logic [ADDR_WIDTH-1:0]         beat_count,
  input  logic                          ce0,
  input  logic [ADDR_WIDTH-1:0]         address0,
  output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0] q0,
  output logic [31:0]                   checksum
);

  localparam int LANES  = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
  localparam int DATA_W = WEIGHT_PRECISION_0 * LANES;
  localparam int IDX_W  = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;

  // Fractional width is only metadata for consumers; reject impossible formats at elaboration.
  if (WEIGHT_PRECISION_1 > WEIGHT_PRECISION_0) begin : g_bad_frac_width
    $error("encoder_weight_sink: fractional bits exceed element width");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [DATA_W-1:0]     ram [IN_DEPTH];
  logic [DATA_W-1:0]     stage1;
  logic [DATA_W-1:0]     packed_in;
  logic                  handshake;
  logic                  accept;
  logic                  last_beat;
  logic                  addr_ok;

  always_comb begin
    packed_in = '0;
    for (int j = 0; j < LANES; j++) begin
      packed_in[j*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0] = data_in[j];
    end
  end

  assign handshake = data_in_valid & data_in_ready;
  // A restart request in the same cycle wins over the beat on the bus.
  assign accept    = (state == LOAD) & handshake & ~load_start;
  assign last_beat = (wr_ptr == ADDR_WIDTH'(IN_DEPTH - 1));
  assign addr_ok   = (address0 < ADDR_WIDTH'(IN_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      beat_count    <= '0;
      data_in_ready <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state         <= LOAD;
            wr_ptr        <= '0;
            beat_count    <= '0;
            data_in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            wr_ptr     <= '0;
            beat_count <= '0;
          end else if (handshake) begin
            wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
            beat_count <= beat_count + ADDR_WIDTH'(1);
            if (last_beat) begin
              state         <= FULL;
              data_in_ready <= 1'b0;
              load_done     <= 1'b1;
            end
          end
        end
        FULL: begin
          if (load_start) begin
            state         <= LOAD;
            wr_ptr        <= '0;
            beat_count    <= '0;
            load_done     <= 1'b0;
            data_in_ready <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          data_in_ready <= 1'b0;
          load_done     <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      ram[wr_ptr[IDX_W-1:0]] <= packed_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage1 <= '0;
      q0     <= '0;
    end else if (ce0) begin
      stage1 <= addr_ok ? ram[address0[IDX_W-1:0]] : '0;
      q0     <= stage1;
    end
  end

`ifdef WEIGHT_SINK_CHECKSUM_EN
  logic [31:0] lane_sum;
  logic [31:0] sum_acc;

  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_sum = lane_sum + 32'(data_in[j]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_acc <= '0;
    end else if (load_start) begin
      sum_acc <= '0;
    end else if (accept) begin
      sum_acc <= sum_acc + lane_sum;
    end
  end

  assign checksum = sum_acc;
`else
  assign checksum = '0;
`endif

endmodule

`default_nettype wire
